// File: rtl/systolic_feeder_if.sv
// Bundle of operand-load, control and array-edge signals between a host and systolic_feeder.
// The master side is the host/array; the slave side is the feeder itself.
interface systolic_feeder_if #(
  parameter int N = 2
);
  localparam int AW = (N * N > 1) ? $clog2(N * N) : 1;

  logic                  wr_en;
  logic                  wr_sel;
  logic [AW-1:0]         wr_addr;
  logic [7:0]            wr_data;
  logic                  start;
  logic [N*N-1:0]        pdone;
  logic [N-1:0][7:0]     a_out;
  logic [N-1:0][7:0]     b_out;
  logic                  arr_enable;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, start, pdone,
    input  a_out, b_out, arr_enable, busy, done, err
  );

  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, start, pdone,
    output a_out, b_out, arr_enable, busy, done, err
  );
endinterface

// File: rtl/systolic_feeder.sv
// Loads two NxN byte matrices, then streams them diagonally skewed into a systolic array's
// row and column edges and keeps the array enabled until every PE reports done.
module systolic_feeder #(
  parameter int N       = 2,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  systolic_feeder_if.slave  bus
);
  localparam int AW = (N * N > 1) ? $clog2(N * N) : 1;
  localparam int TW = $clog2(2 * N);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] LAST_STEP = TW'(2 * N - 2);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            state, state_n;
  logic [TW-1:0]     step, step_n;
  logic [CW-1:0]     wcnt, wcnt_n;
  logic              err_n;
  logic              feed_n;
  logic              arr_en_n;
  logic              busy_n;
  logic              done_n;
  logic              pdone_all;

  logic [7:0]        a_mem  [N][N];
  logic [7:0]        b_mem  [N][N];
  logic [7:0]        a_term [N][N];
  logic [7:0]        b_term [N][N];
  logic [7:0]        a_acc  [N][N];
  logic [7:0]        b_acc  [N][N];
  logic [N-1:0][7:0] a_sel;
  logic [N-1:0][7:0] b_sel;

  assign pdone_all = &bus.pdone;

  // Operand buffers only accept writes while idle so a run never sees operands change under it.
  for (genvar r = 0; r < N; r++) begin : g_mem_row
    for (genvar c = 0; c < N; c++) begin : g_mem_col
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_mem[r][c] <= 8'd0;
          b_mem[r][c] <= 8'd0;
        end else if (bus.wr_en && (state == S_IDLE) && (bus.wr_addr == AW'(r * N + c))) begin
          if (bus.wr_sel) begin
            b_mem[r][c] <= bus.wr_data;
          end else begin
            a_mem[r][c] <= bus.wr_data;
          end
        end
      end
    end
  end

  // Element (r,c) reaches the edge at step r+c; each edge lane ORs its one matching element.
  for (genvar i = 0; i < N; i++) begin : g_lane
    for (genvar k = 0; k < N; k++) begin : g_elem
      assign a_term[i][k] = (step_n == TW'(i + k)) ? a_mem[i][k] : 8'd0;
      assign b_term[i][k] = (step_n == TW'(i + k)) ? b_mem[k][i] : 8'd0;
      if (k == 0) begin : g_first
        assign a_acc[i][k] = a_term[i][k];
        assign b_acc[i][k] = b_term[i][k];
      end else begin : g_rest
        assign a_acc[i][k] = a_acc[i][k-1] | a_term[i][k];
        assign b_acc[i][k] = b_acc[i][k-1] | b_term[i][k];
      end
    end
    assign a_sel[i] = a_acc[i][N-1];
    assign b_sel[i] = b_acc[i][N-1];
  end

  // Next-state logic also computes the next value of every output so they can all be registered.
  always_comb begin
    state_n  = state;
    step_n   = step;
    wcnt_n   = wcnt;
    err_n    = bus.err;
    feed_n   = 1'b0;
    arr_en_n = 1'b0;
    done_n   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_n  = S_FEED;
          step_n   = '0;
          err_n    = 1'b0;
          feed_n   = 1'b1;
          arr_en_n = 1'b1;
        end
      end
      S_FEED: begin
        arr_en_n = 1'b1;
        if (step == LAST_STEP) begin
          state_n = S_WAIT;
          wcnt_n  = '0;
        end else begin
          step_n = step + TW'(1);
          feed_n = 1'b1;
        end
      end
      S_WAIT: begin
        if (pdone_all) begin
          state_n = S_DONE;
          done_n  = 1'b1;
        end else if (wcnt == WAIT_LAST) begin
          state_n = S_DONE;
          done_n  = 1'b1;
          err_n   = 1'b1;
        end else begin
          wcnt_n   = wcnt + CW'(1);
          arr_en_n = 1'b1;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      step           <= '0;
      wcnt           <= '0;
      bus.a_out      <= '0;
      bus.b_out      <= '0;
      bus.arr_enable <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.err        <= 1'b0;
    end else begin
      state          <= state_n;
      step           <= step_n;
      wcnt           <= wcnt_n;
      bus.a_out      <= feed_n ? a_sel : '0;
      bus.b_out      <= feed_n ? b_sel : '0;
      bus.arr_enable <= arr_en_n;
      bus.busy       <= busy_n;
      bus.done       <= done_n;
      bus.err        <= err_n;
    end
  end
endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Operand sequencer on the input side of the N×N systolic multiplier array: software/host loads two N×N byte matrices A and B into local registers, then on `start` the block streams them into the array's row (A) and column (B) edges with the diagonal skew the array requires. It holds the array enabled until every per-PE done flag is set, then reports completion. Owns the array's `enable`; the array's `out` bus is read by downstream logic, not by this block.

## Interface

- `N`, 2: array dimension; must match the array instance.
- `TIMEOUT`, 64: maximum cycles spent in WAIT before aborting with `err`.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  write strobe for the operand buffers.
- `wr_sel`  in  1  0 = A buffer, 1 = B buffer.
- `wr_addr`  in  max(1,$clog2(N*N))  element index = row*N + col.
- `wr_data`  in  8  element value (unsigned).
- `start`  in  1  launch one multiply.
- `pdone`  in  N*N  per-PE done flags from the array, index i*N+j.
- `a_out`  out  8 × [N-1:0]  row-edge operands; `a_out[i]` drives array row i.
- `b_out`  out  8 × [N-1:0]  column-edge operands; `b_out[j]` drives array column j.
- `arr_enable`  out  1  drives the array `enable`.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  sticky timeout flag; cleared by the next accepted `start` or reset.

## Operation

- Buffers: `A_mem[N][N]`, `B_mem[N][N]`, 8-bit each. Writes accepted only in IDLE; writes in any other state are dropped. Out-of-range `wr_addr` (≥ N*N) dropped.
- FSM: IDLE → FEED → WAIT → DONE → IDLE.
  - IDLE: `start`=1 → FEED, step counter t=0, `err` cleared. `start` outside IDLE ignored.
  - FEED: lasts exactly 2N-1 cycles, t = 0..2N-2; after t=2N-2 → WAIT.
  - WAIT: `a_out`/`b_out` all zero, `arr_enable` held 1. `pdone` all ones → DONE. Wait counter reaching TIMEOUT → DONE with `err` set. If both occur in the same cycle, `pdone` wins (no `err`).
  - DONE: `done`=1 for this single cycle, `arr_enable`=0 → IDLE.
- Skew rule during FEED step t: `a_out[i]` = A_mem[i][t-i] if 0 ≤ t-i < N, else 0. `b_out[j]` = B_mem[t-j][j] if 0 ≤ t-j < N, else 0.
- `pdone` is ignored outside WAIT (stale flags from a previous run must not terminate FEED).
- Buffers retain contents across runs; a second `start` without new writes repeats the same operands.

## Timing

- All outputs registered. Reset values: `a_out`=0, `b_out`=0, `arr_enable`=0, `busy`=0, `done`=0, `err`=0, FSM=IDLE, buffers all 0, counters 0.
- `start` sampled high at edge k in IDLE → from edge k+1: `busy`=1, `arr_enable`=1, `a_out`/`b_out` show step t=0.
- Step t is presented in cycle k+1+t; first WAIT cycle is k+2N.
- `pdone` all ones sampled at edge m in WAIT → cycle after m: `done`=1, `arr_enable`=0, `busy`=1; next cycle IDLE, `busy`=0.
- Timeout: WAIT entered at edge w; if `pdone` never completes, DONE entered at edge w+TIMEOUT.
- `rst` asserted mid-run: all outputs and buffers to reset values immediately, no `done` pulse.
- `start` held high continuously: one run per IDLE visit; re-launch occurs on the first IDLE cycle after DONE.

## Test plan

- N=2, load A={{1,2},{3,4}}, B={{5,6},{7,8}}, pulse `start` → steps t0: a_out={1,0}, b_out={5,0}; t1: a_out={2,3}, b_out={7,6}; t2: a_out={0,4}, b_out={0,8}; then zeros, `arr_enable` high from t0 through WAIT.
- Same run, drive `pdone`=4'b1111 three cycles after WAIT entry → `done` one cycle exactly one cycle later, `err`=0, `busy` low the following cycle.
- Hold `pdone`=4'b1111 during FEED, then 0 on WAIT entry → FEED completes all 3 steps; no early `done`.
- TIMEOUT=8, `pdone` stuck 4'b0111 → `done` and `err`=1 eight cycles after WAIT entry; next `start` clears `err`.
- Write `wr_data`=0xFF to A[0] while busy, and `start` pulses mid-FEED → A[0] unchanged (next run shows original value); no restart, step sequence uninterrupted.
- Assert `rst` at FEED step t1 → all outputs 0 next cycle, buffers zeroed; subsequent `start` without writes streams all-zero operands.
